// File: rtl/fix_mult_drv.sv
// On-chip initiator for the fix_mult valid-in/valid-out interface: issues buffered operand pairs
// at a fixed spacing and captures the returned products in order. Optional watchdog: FIX_MULT_DRV_WATCHDOG_EN.
module fix_mult_drv #(
    parameter int WIDTHa  = 16,
    parameter int WIDTHb  = 16,
    parameter int WIDTHr  = 16,
    parameter int DEPTH   = 512,
    parameter int AW      = 9,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ld_we,
    input  logic [AW-1:0]     ld_addr,
    input  logic [WIDTHa-1:0] ld_a,
    input  logic [WIDTHb-1:0] ld_b,
    input  logic [AW:0]       len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_overrun,
    output logic              err_timeout,
    output logic              m_vld_in,
    output logic [WIDTHa-1:0] m_a,
    output logic [WIDTHb-1:0] m_b,
    input  logic              m_vld_out,
    input  logic [WIDTHr-1:0] m_r,
    input  logic [AW-1:0]     rd_addr,
    output logic [WIDTHr-1:0] rd_data
);

    localparam int            OW       = WIDTHa + WIDTHb;
    localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE      = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [3:0]    GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_GAP, S_DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [OW-1:0]     op_ram  [DEPTH];
    logic [WIDTHr-1:0] res_ram [DEPTH];
    logic [OW-1:0]     op_q;
    logic [AW-1:0]     op_rd_addr;

    logic [AW:0]       len_q;
    logic [AW:0]       len_clamped;
    logic [AW:0]       iss_cnt;
    logic [AW:0]       cap_cnt;
    logic [3:0]        gap_cnt;

    logic              accept;
    logic              cap_ok;
    logic              last_issue;
    logic              drain_fin;
    logic              wd_expire;
    logic              issue_now;
    logic              finish;
    logic              zero_done;
    logic              busy_set;

    assign accept      = (state == S_IDLE) && start;
    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
    assign cap_ok      = (state != S_IDLE) && (cap_cnt < len_q) && m_vld_out;
    assign last_issue  = (iss_cnt + ONE) == len_q;
    // The final capture ends the run on its own edge so busy/done line up with it.
    assign drain_fin   = (state == S_DRAIN) &&
                         ((cap_cnt == len_q) || (cap_ok && ((cap_cnt + ONE) == len_q)));

`ifdef FIX_MULT_DRV_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_cnt;
    logic          wd_active;

    assign wd_active = ((state == S_ISSUE) || (state == S_GAP) || (state == S_DRAIN)) &&
                       (cap_cnt < iss_cnt);
    assign wd_expire = wd_active && !cap_ok && (wd_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt <= '0;
        end else if (!wd_active || cap_ok) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + TW'(1);
        end
    end
`else
    assign wd_expire = 1'b0 && (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && (len_clamped != '0)) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (last_issue) begin
                    state_nxt = S_DRAIN;
                end else if (GAP == 0) begin
                    state_nxt = S_ISSUE;
                end else begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_ISSUE;
            S_DRAIN: if (drain_fin) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (wd_expire) state_nxt = S_IDLE;
    end

    // During ISSUE the counter has not yet advanced, so prefetch one entry ahead.
    always_comb begin
        issue_now  = 1'b0;
        busy_set   = 1'b0;
        finish     = drain_fin || wd_expire;
        zero_done  = accept && (len_clamped == '0);
        op_rd_addr = iss_cnt[AW-1:0];
        case (state)
            S_FETCH: busy_set = 1'b1;
            S_ISSUE: begin
                issue_now  = 1'b1;
                op_rd_addr = iss_cnt[AW-1:0] + ONE_A;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q   <= '0;
            iss_cnt <= '0;
            cap_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept) begin
                len_q   <= len_clamped;
                iss_cnt <= '0;
                cap_cnt <= '0;
            end else begin
                if (issue_now) iss_cnt <= iss_cnt + ONE;
                if (cap_ok)    cap_cnt <= cap_cnt + ONE;
            end
            if ((state == S_GAP) && (gap_cnt != GAP_LAST)) begin
                gap_cnt <= gap_cnt + 4'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            m_vld_in    <= 1'b0;
            m_a         <= '0;
            m_b         <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (finish) begin
                busy <= 1'b0;
            end else if (busy_set) begin
                busy <= 1'b1;
            end
            done     <= finish || zero_done;
            m_vld_in <= issue_now;
            if (issue_now) begin
                m_a <= op_q[OW-1:WIDTHb];
                m_b <= op_q[WIDTHb-1:0];
            end
            if (m_vld_out && !cap_ok) begin
                err_overrun <= 1'b1;
            end else if (accept) begin
                err_overrun <= 1'b0;
            end
            if (wd_expire) begin
                err_timeout <= 1'b1;
            end else if (accept) begin
                err_timeout <= 1'b0;
            end
        end
    end

    // Buffer contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (ld_we && (state == S_IDLE) && !busy) begin
            op_ram[ld_addr] <= {ld_a, ld_b};
        end
        op_q <= op_ram[op_rd_addr];
        if (cap_ok) begin
            res_ram[cap_cnt[AW-1:0]] <= m_r;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
        end else begin
            rd_data <= res_ram[rd_addr];
        end
    end

endmodule

// File: doc/fix_mult_drv.md
# fix_mult_drv

On-chip initiator for the `fix_mult` valid-in/valid-out interface. It holds a buffer of operand pairs, issues them to the multiplier at a fixed spacing, and captures every returned product into a result buffer in arrival order. When all results are in, it signals completion. It replaces file-driven stimulus for on-board validation of the multiplier, and later feeds twiddle products in the FFT datapath.

## Interface
- `WIDTHa`, 16: operand a width (q9.7)
- `WIDTHb`, 16: operand b width (q2.14 cos/sin)
- `WIDTHr`, 16: result width (q11.5)
- `DEPTH`, 512: operand/result buffer entries
- `AW`, 9: address width, equal to clog2(DEPTH)
- `GAP`, 1: idle cycles between issues, range 0..15
- `TIMEOUT`, 64: watchdog limit in cycles (used only with the macro)

- `clk`  in  1: clock, rising edge
- `rstn`  in  1: asynchronous, active-low reset
- `ld_we`  in  1: operand buffer write strobe
- `ld_addr`  in  AW: operand write address
- `ld_a`  in  WIDTHa: operand a write data
- `ld_b`  in  WIDTHb: operand b write data
- `len`  in  AW+1: number of pairs to run, sampled on `start`
- `start`  in  1: start pulse
- `busy`  out  1: run in progress
- `done`  out  1: one-cycle completion pulse
- `err_overrun`  out  1: sticky; an unexpected result arrived
- `err_timeout`  out  1: sticky; the watchdog expired
- `m_vld_in`  out  1: to `fix_mult` `vld_in`
- `m_a`  out  WIDTHa: to `fix_mult` `a`
- `m_b`  out  WIDTHb: to `fix_mult` `b`
- `m_vld_out`  in  1: from `fix_mult` `vld_out`
- `m_r`  in  WIDTHr: from `fix_mult` `r`
- `rd_addr`  in  AW: result readback address
- `rd_data`  out  WIDTHr: result readback data, registered

## Operation
- **Buffers:** operand and result RAMs use synchronous read. Contents are not reset.
- **Loading:** `ld_we` writes `{ld_a, ld_b}` at `ld_addr` only while `busy=0`. It is ignored while busy.
- **FSM states:** IDLE, FETCH, ISSUE, GAP, DRAIN.
  - IDLE: `start=1` with `len` in 1..DEPTH latches `len`, clears `iss_cnt` and `cap_cnt`, and goes to FETCH. `len=0` pulses `done` with no issue. `len>DEPTH` is clamped to DEPTH.
  - FETCH: the operand RAM is read at `iss_cnt`, then the FSM goes to ISSUE.
  - ISSUE: `m_a`/`m_b` are registered from the RAM output, `m_vld_in=1` for exactly one cycle, and `iss_cnt` increments.
    - If `iss_cnt` now equals `len`, go to DRAIN.
    - Else if GAP=0, go back to ISSUE (back-to-back; the next read is prefetched).
    - Else go to GAP.
  - GAP: hold `m_vld_in=0` for GAP cycles, then go to ISSUE (the read is prefetched in the final GAP cycle).
  - DRAIN: wait for `cap_cnt==len`, then pulse `done` and return to IDLE.
- **Capture:** in any non-IDLE state with `cap_cnt<len`, `m_vld_out=1` writes `m_r` to result[`cap_cnt`] and increments `cap_cnt`. Capture runs concurrently with issuing.
  - `m_vld_out=1` in IDLE, or with `cap_cnt==len`, sets `err_overrun` and the result is discarded.
- **Multiplier latency:** not assumed. Results are matched to operands by order only.
- **`start` while busy:** ignored.
- **Error clearing:** a new accepted `start` clears `err_overrun` and `err_timeout`.
- **`m_a`/`m_b` between issues:** hold the last issued values.

## Timing
- **Reset values:** `busy=0`, `done=0`, `err_overrun=0`, `err_timeout=0`, `m_vld_in=0`, `m_a=0`, `m_b=0`, `rd_data=0`, state IDLE, all counters 0.
- **Reset mid-run:** aborts immediately. All outputs return to reset values; no `done` is produced.
- **Start to first issue:** with `start` sampled at edge k, `busy=1` from edge k+1 and the first `m_vld_in` is high from edge k+2.
- **Issue spacing:** issues are GAP+1 cycles apart. The last issue is at edge k+2+(len-1)(GAP+1).
- **Completion:**
  - `done` is high for the one cycle after the edge that captures the final result.
  - `busy` falls on the same edge that `done` rises.
- **Readback:** `rd_data` is valid one cycle after `rd_addr`. Reading while busy is allowed; entries not yet written return stale data.

## Configuration
- **`FIX_MULT_DRV_WATCHDOG_EN` defined:**
  - A counter runs in ISSUE, GAP and DRAIN while `cap_cnt<iss_cnt` (results are outstanding). It resets on every capture.
  - On reaching TIMEOUT: set `err_timeout`, pulse `done`, return to IDLE. `cap_cnt` keeps the partial count.
- **Undefined:** no counter; `err_timeout` is tied to 0. A dead multiplier leaves the block in DRAIN until reset.

## Test plan
- **Basic run:** load 4 pairs (0x0100,0x2000), (0xFF00,0x2000), (0x0080,0xE000), (0x7FFF,0x4000); attach the real `fix_mult`; GAP=1, `len=4` -> `m_vld_in` pulses every 2 cycles starting at k+2; result[0..3] match the bit-exact `fix_mult` outputs; one `done`, and `busy` low afterwards.
- **Back-to-back:** GAP=0, `len=512`, stub multiplier with latency 3 that returns `a^b` -> 512 consecutive `m_vld_in` cycles; result[i] = a[i]^b[i] for all i; `done` at k+2+511+3+1.
- **Spurious result:** inject `m_vld_out` in IDLE, and an extra one after the last result -> `err_overrun=1`; the result buffer is unchanged; the next `start` clears it.
- **Ignored inputs:** `start` and `ld_we` asserted mid-run -> ignored; `len`, `iss_cnt` and operand contents are unchanged; the run completes normally.
- **Reset and zero length:** `rstn` pulsed low after 10 issues -> all outputs return to reset values at once. A later `start` with `len=0` gives `done` the next cycle with no `m_vld_in`.
- **Watchdog (macro defined):** stub multiplier stops after 5 results, `len=8`, TIMEOUT=64 -> `err_timeout=1` and `done` exactly 64 cycles after the last capture; `cap_cnt=5`.
